// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU, data-SRAM request, HI/LO and iterative divider.
// Define ITER_MUL_EN to run mult/multu on the iterative datapath instead of a 1-cycle multiplier.
`ifndef StallBus
`define StallBus 6
`endif

module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int DIV_CYCLES   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`StallBus-1:0]    stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_id_bus,
    output logic                    inst_is_load,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    localparam int CW = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    logic advance;
    logic bubble;

    assign advance = ~stall[2];
    assign bubble  = stall[2] & ~stall[3];

    logic [ID_TO_EX_WD-1:0] bus_q, bus_d;

    always_comb begin
        bus_d = bus_q;
        if (bubble) begin
            bus_d = '0;
        end else if (advance) begin
            bus_d = id_to_ex_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= '0;
        end else begin
            bus_q <= bus_d;
        end
    end

    logic [31:0] pc, inst, rs_v, rt_v;
    logic [11:0] alu_op;
    logic [2:0]  sel1;
    logic [3:0]  sel2;
    logic        ram_en, rf_we, sel_res;
    logic [3:0]  ram_wen;
    logic [4:0]  waddr;

    assign {pc, inst, alu_op, sel1, sel2, ram_en, ram_wen,
            rf_we, waddr, sel_res, rs_v, rt_v} = bus_q;

    logic [31:0] imm_sext, imm_zext, sa_zext, src1, src2;

    assign imm_sext = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext = {16'b0, inst[15:0]};
    assign sa_zext  = {27'b0, inst[10:6]};

    assign src1 = ({32{sel1[0]}} & rs_v)
                | ({32{sel1[1]}} & pc)
                | ({32{sel1[2]}} & sa_zext);
    assign src2 = ({32{sel2[0]}} & rt_v)
                | ({32{sel2[1]}} & imm_sext)
                | ({32{sel2[2]}} & 32'd8)
                | ({32{sel2[3]}} & imm_zext);

    // alu_op one-hot: add sub slt sltu and nor or xor sll srl sra lui (MSB first)
    logic [31:0] alu_res;
    logic        slt_bit, sltu_bit;

    assign slt_bit  = $signed(src1) < $signed(src2);
    assign sltu_bit = src1 < src2;

    always_comb begin
        alu_res = '0;
        if (alu_op[11]) alu_res = alu_res | (src1 + src2);
        if (alu_op[10]) alu_res = alu_res | (src1 - src2);
        if (alu_op[9])  alu_res = alu_res | {31'b0, slt_bit};
        if (alu_op[8])  alu_res = alu_res | {31'b0, sltu_bit};
        if (alu_op[7])  alu_res = alu_res | (src1 & src2);
        if (alu_op[6])  alu_res = alu_res | ~(src1 | src2);
        if (alu_op[5])  alu_res = alu_res | (src1 | src2);
        if (alu_op[4])  alu_res = alu_res | (src1 ^ src2);
        if (alu_op[3])  alu_res = alu_res | (src2 << src1[4:0]);
        if (alu_op[2])  alu_res = alu_res | (src2 >> src1[4:0]);
        if (alu_op[1])  alu_res = alu_res | 32'($signed(src2) >>> src1[4:0]);
        if (alu_op[0])  alu_res = alu_res | {src2[15:0], 16'b0};
    end

    logic is_r;
    logic op_mult, op_multu, op_div, op_divu;
    logic op_mfhi, op_mflo, op_mthi, op_mtlo;

    assign is_r     = inst[31:26] == 6'h00;
    assign op_mult  = is_r & (inst[5:0] == 6'h18);
    assign op_multu = is_r & (inst[5:0] == 6'h19);
    assign op_div   = is_r & (inst[5:0] == 6'h1A);
    assign op_divu  = is_r & (inst[5:0] == 6'h1B);
    assign op_mfhi  = is_r & (inst[5:0] == 6'h10);
    assign op_mthi  = is_r & (inst[5:0] == 6'h11);
    assign op_mflo  = is_r & (inst[5:0] == 6'h12);
    assign op_mtlo  = is_r & (inst[5:0] == 6'h13);

    logic iter_op, iter_mul, iter_signed;

`ifdef ITER_MUL_EN
    assign iter_mul = op_mult | op_multu;
`else
    assign iter_mul = 1'b0;
`endif
    assign iter_op     = op_div | op_divu | iter_mul;
    assign iter_signed = op_div | op_mult;

    logic        a_neg, b_neg;
    logic [31:0] abs_a, abs_b;

    assign a_neg = iter_signed & rs_v[31];
    assign b_neg = iter_signed & rt_v[31];
    assign abs_a = a_neg ? (~rs_v + 32'd1) : rs_v;
    assign abs_b = b_neg ? (~rt_v + 32'd1) : rt_v;

    state_e        state_q, state_d;
    logic          started_q, started_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [64:0]   w_q, w_d;
    logic [31:0]   b_q, b_d;
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
    logic          dvz_q, dvz_d;
    logic          mul_q, mul_d;
    logic          commit;

    // w holds {remainder, quotient} when dividing, {partial product, multiplier} when multiplying
    logic [64:0] sh, div_step, mul_step, step;
    logic [32:0] diff, sum;

    assign sh       = {w_q[63:0], 1'b0};
    assign diff     = sh[64:32] - {1'b0, b_q};
    assign div_step = diff[32] ? sh : {diff, sh[31:1], 1'b1};
    assign sum      = w_q[64:32] + {1'b0, (w_q[0] ? b_q : 32'b0)};
    assign mul_step = {1'b0, sum, w_q[31:1]};
    assign step     = mul_q ? mul_step : div_step;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix, res_hi, res_lo;

    assign prod_fix = negq_q ? (~step[63:0] + 64'd1) : step[63:0];
    assign quo_fix  = negq_q ? (~step[31:0] + 32'd1) : step[31:0];
    assign rem_fix  = negr_q ? (~step[63:32] + 32'd1) : step[63:32];
    assign res_hi   = mul_q ? prod_fix[63:32] : rem_fix;
    assign res_lo   = mul_q ? prod_fix[31:0]
                    : (dvz_q ? 32'hFFFF_FFFF : quo_fix);

    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        b_d       = b_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        dvz_d     = dvz_q;
        mul_d     = mul_q;
        commit    = 1'b0;
        if (bubble) begin
            state_d   = IDLE;
            started_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (iter_op && !started_q) begin
                        state_d   = RUN;
                        started_d = 1'b1;
                        cnt_d     = '0;
                        w_d       = {33'b0, abs_a};
                        b_d       = abs_b;
                        negq_d    = a_neg ^ b_neg;
                        negr_d    = a_neg;
                        dvz_d     = ~iter_mul & (rt_v == 32'b0);
                        mul_d     = iter_mul;
                    end
                end
                RUN: begin
                    w_d   = step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end
                end
                DONE: begin
                    if (advance) begin
                        state_d   = IDLE;
                        started_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            cnt_q     <= '0;
            w_q       <= '0;
            b_q       <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            dvz_q     <= 1'b0;
            mul_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            cnt_q     <= cnt_d;
            w_q       <= w_d;
            b_q       <= b_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            dvz_q     <= dvz_d;
            mul_q     <= mul_d;
        end
    end

    assign stallreq_for_ex = (state_q == RUN)
                           | ((state_q == IDLE) & iter_op & ~started_q);

    logic [31:0] hi_q, hi_d, lo_q, lo_d;

`ifndef ITER_MUL_EN
    logic [63:0] prod_s, prod_u;

    assign prod_s = {{32{rs_v[31]}}, rs_v} * {{32{rt_v[31]}}, rt_v};
    assign prod_u = {32'b0, rs_v} * {32'b0, rt_v};
`endif

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (commit) begin
            hi_d = res_hi;
            lo_d = res_lo;
        end else if (advance) begin
`ifndef ITER_MUL_EN
            if (op_mult)  {hi_d, lo_d} = prod_s;
            if (op_multu) {hi_d, lo_d} = prod_u;
`endif
            if (op_mthi) hi_d = rs_v;
            if (op_mtlo) lo_d = rs_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    logic [31:0] ex_result;
    logic        rf_we_o;
    logic [4:0]  waddr_o;

    assign ex_result = op_mfhi ? hi_q : (op_mflo ? lo_q : alu_res);
    assign rf_we_o   = rf_we | op_mfhi | op_mflo;
    assign waddr_o   = (op_mfhi | op_mflo) ? inst[15:11] : waddr;

    assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_res,
                              rf_we_o, waddr_o, ex_result};
    assign ex_to_id_bus    = {rf_we_o, waddr_o, ex_result};
    assign inst_is_load    = sel_res;
    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = rs_v + imm_sext;
    assign data_sram_wdata = rt_v;

    logic unused_ok;
    assign unused_ok = ^{stall[`StallBus-1:4], stall[1:0], inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed checks of ex_stage ALU, memory request, HI/LO and divider stalls.
// A small stall controller turns stallreq_for_ex into stall = 6'b001111 unless forced.
`timescale 1ns/1ps

module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id_bus;
  logic         inst_is_load, stallreq_for_ex, data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;

  logic         force_en;
  logic [5:0]   force_v;

  int n_checks = 0;
  int n_err    = 0;
  int n;

  always #5 clk = ~clk;

  assign stall = force_en ? force_v
               : (stallreq_for_ex ? 6'b001111 : 6'b000000);

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .inst_is_load    (inst_is_load),
    .stallreq_for_ex (stallreq_for_ex),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata)
  );

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;
  localparam logic [31:0] PC0     = 32'h0040_0000;

  task automatic chk(input string tag, input logic ok,
                     input logic [75:0] obs, input logic [75:0] exp);
    n_checks++;
    if (ok !== 1'b1) begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [158:0] mk(
    input logic [31:0] pc, input logic [31:0] inst,
    input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
    input logic ren, input logic [3:0] wen, input logic we,
    input logic [4:0] wa, input logic sel,
    input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, sel, rs, rt};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rd,
                                        input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, rd, sa, fn};
  endfunction

  function automatic logic [158:0] f_r(input logic [5:0] fn,
                                       input logic [4:0] rd,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    return mk(PC0, rtype(rd, 5'd0, fn), 12'h0, 3'b001, 4'b0001,
              1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
  endfunction

  task automatic issue(input logic [158:0] b);
    @(negedge clk);
    id = b;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_iter(output int cnt);
    cnt = 0;
    while (stallreq_for_ex && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    id       = '0;
    force_en = 1'b0;
    force_v  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_bus", ex_to_mem_bus === 76'd0, ex_to_mem_bus, 76'd0);
    chk("rst_id_bus", ex_to_id_bus === 38'd0, 76'(ex_to_id_bus), 76'd0);
    chk("rst_ctrl",
        {inst_is_load, stallreq_for_ex, data_sram_en, data_sram_wen} === 7'd0,
        76'({inst_is_load, stallreq_for_ex, data_sram_en, data_sram_wen}),
        76'd0);
    chk("rst_sram", {data_sram_addr, data_sram_wdata} === 64'd0,
        76'({data_sram_addr, data_sram_wdata}), 76'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(mk(PC0, rtype(5'd3, 5'd0, 6'h21), OP_ADD, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd7, 32'd5));
    chk("addu_res", ex_to_mem_bus[31:0] === 32'd12,
        76'(ex_to_mem_bus[31:0]), 76'd12);
    chk("addu_fwd", ex_to_id_bus === {1'b1, 5'd3, 32'd12},
        76'(ex_to_id_bus), 76'({1'b1, 5'd3, 32'd12}));
    chk("addu_noload", inst_is_load === 1'b0, 76'(inst_is_load), 76'd0);

    issue(mk(PC0, {6'h23, 5'd4, 5'd9, 16'hFFFC}, OP_ADD, 3'b001, 4'b0010,
             1'b1, 4'h0, 1'b1, 5'd9, 1'b1, 32'h1000, 32'h55));
    chk("lw_ctrl", {data_sram_en, data_sram_wen, inst_is_load} === 6'b1_0000_1,
        76'({data_sram_en, data_sram_wen, inst_is_load}), 76'(6'b1_0000_1));
    chk("lw_addr", data_sram_addr === 32'h0000_0FFC,
        76'(data_sram_addr), 76'(32'h0000_0FFC));
    chk("lw_wdata", data_sram_wdata === 32'h55,
        76'(data_sram_wdata), 76'(32'h55));

    issue(mk(PC0, rtype(5'd4, 5'd0, 6'h23), OP_SUB, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd5, 32'd7));
    chk("sub", ex_to_mem_bus[31:0] === 32'hFFFF_FFFE,
        76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFE));
    issue(mk(PC0, rtype(5'd4, 5'd0, 6'h2A), OP_SLT, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1));
    chk("slt", ex_to_mem_bus[31:0] === 32'd1,
        76'(ex_to_mem_bus[31:0]), 76'd1);
    issue(mk(PC0, rtype(5'd4, 5'd0, 6'h2B), OP_SLTU, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'hFFFF_FFFF, 32'd1));
    chk("sltu", ex_to_mem_bus[31:0] === 32'd0,
        76'(ex_to_mem_bus[31:0]), 76'd0);
    issue(mk(PC0, rtype(5'd4, 5'd4, 6'h03), OP_SRA, 3'b100, 4'b0001,
             1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'h0, 32'h8000_0000));
    chk("sra", ex_to_mem_bus[31:0] === 32'hF800_0000,
        76'(ex_to_mem_bus[31:0]), 76'(32'hF800_0000));
    issue(mk(PC0, {6'h0F, 5'd0, 5'd2, 16'h1234}, OP_LUI, 3'b000, 4'b1000,
             1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h0, 32'h0));
    chk("lui", ex_to_mem_bus[31:0] === 32'h1234_0000,
        76'(ex_to_mem_bus[31:0]), 76'(32'h1234_0000));
    issue(mk(32'h0040_0010, {6'h03, 26'h0}, OP_ADD, 3'b010, 4'b0100,
             1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0));
    chk("jal_link", ex_to_mem_bus[31:0] === 32'h0040_0018,
        76'(ex_to_mem_bus[31:0]), 76'(32'h0040_0018));

    @(negedge clk);
    id = f_r(6'h1A, 5'd0, 32'hFFFF_FFF9, 32'd2);
    @(negedge clk);
    id = f_r(6'h12, 5'd8, 32'h0, 32'h0);
    wait_iter(n);
    chk("div_stall_len", n === 33, 76'(n), 76'd33);
    chk("div_mflo_fwd", ex_to_id_bus === {1'b1, 5'd8, 32'hFFFF_FFFD},
        76'(ex_to_id_bus), 76'({1'b1, 5'd8, 32'hFFFF_FFFD}));
    issue(f_r(6'h10, 5'd9, 32'h0, 32'h0));
    chk("div_hi", ex_to_mem_bus[31:0] === 32'hFFFF_FFFF,
        76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFF));

    @(negedge clk);
    id = f_r(6'h1B, 5'd0, 32'd9, 32'd0);
    @(negedge clk);
    id = f_r(6'h10, 5'd10, 32'h0, 32'h0);
    wait_iter(n);
    chk("dvz_stall_len", n === 33, 76'(n), 76'd33);
    chk("dvz_hi", ex_to_mem_bus[31:0] === 32'd9,
        76'(ex_to_mem_bus[31:0]), 76'd9);
    issue(f_r(6'h12, 5'd10, 32'h0, 32'h0));
    chk("dvz_lo", ex_to_mem_bus[31:0] === 32'hFFFF_FFFF,
        76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFF));

    @(negedge clk);
    id = f_r(6'h1A, 5'd0, 32'd7, 32'd2);
    @(negedge clk);
    id = '0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_run_stallreq", stallreq_for_ex === 1'b0,
        76'(stallreq_for_ex), 76'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(f_r(6'h10, 5'd1, 32'h0, 32'h0));
    chk("rst_run_hi", ex_to_mem_bus[31:0] === 32'd0,
        76'(ex_to_mem_bus[31:0]), 76'd0);
    issue(f_r(6'h12, 5'd1, 32'h0, 32'h0));
    chk("rst_run_lo", ex_to_mem_bus[31:0] === 32'd0,
        76'(ex_to_mem_bus[31:0]), 76'd0);

    @(negedge clk);
    id = f_r(6'h1A, 5'd0, 32'd100, 32'd7);
    @(negedge clk);
    id = f_r(6'h1B, 5'd0, 32'd9, 32'd2);
    wait_iter(n);
    chk("b2b_first_len", n === 33, 76'(n), 76'd33);
    @(negedge clk);
    id = f_r(6'h12, 5'd5, 32'h0, 32'h0);
    wait_iter(n);
    chk("b2b_second_len", n === 33, 76'(n), 76'd33);
    chk("b2b_lo", ex_to_mem_bus[31:0] === 32'd4,
        76'(ex_to_mem_bus[31:0]), 76'd4);
    issue(f_r(6'h10, 5'd5, 32'h0, 32'h0));
    chk("b2b_hi", ex_to_mem_bus[31:0] === 32'd1,
        76'(ex_to_mem_bus[31:0]), 76'd1);

    issue(f_r(6'h11, 5'd0, 32'hDEAD_BEEF, 32'h0));
    @(negedge clk);
    id = f_r(6'h1A, 5'd0, 32'd50, 32'd3);
    @(negedge clk);
    id = '0;
    repeat (5) @(negedge clk);
    force_en = 1'b1;
    force_v  = 6'b000111;
    @(posedge clk);
    #1;
    chk("bubble_stallreq", stallreq_for_ex === 1'b0,
        76'(stallreq_for_ex), 76'd0);
    @(negedge clk);
    force_en = 1'b0;
    @(posedge clk);
    #1;
    chk("bubble_stallreq_after", stallreq_for_ex === 1'b0,
        76'(stallreq_for_ex), 76'd0);
    issue(f_r(6'h10, 5'd6, 32'h0, 32'h0));
    chk("bubble_hi_kept", ex_to_mem_bus[31:0] === 32'hDEAD_BEEF,
        76'(ex_to_mem_bus[31:0]), 76'(32'hDEAD_BEEF));

    @(negedge clk);
    id = f_r(6'h1A, 5'd0, 32'hFFFF_FFEC, 32'hFFFF_FFFD);
    @(negedge clk);
    id = f_r(6'h12, 5'd7, 32'h0, 32'h0);
    n = 0;
    while (stallreq_for_ex && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("hold_stall_len", n === 33, 76'(n), 76'd33);
    force_en = 1'b1;
    force_v  = 6'b001111;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold_no_restart", stallreq_for_ex === 1'b0,
          76'(stallreq_for_ex), 76'd0);
    end
    @(negedge clk);
    force_en = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_lo", ex_to_mem_bus[31:0] === 32'd6,
        76'(ex_to_mem_bus[31:0]), 76'd6);
    issue(f_r(6'h10, 5'd7, 32'h0, 32'h0));
    chk("hold_hi", ex_to_mem_bus[31:0] === 32'hFFFF_FFFE,
        76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFE));

    @(negedge clk);
    id = f_r(6'h19, 5'd0, 32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    id = f_r(6'h10, 5'd11, 32'h0, 32'h0);
    wait_iter(n);
`ifdef ITER_MUL_EN
    chk("multu_stall_len", n === 33, 76'(n), 76'd33);
`else
    chk("multu_stall_len", n === 0, 76'(n), 76'd0);
`endif
    chk("multu_hi", ex_to_mem_bus[31:0] === 32'd1,
        76'(ex_to_mem_bus[31:0]), 76'd1);
    issue(f_r(6'h12, 5'd11, 32'h0, 32'h0));
    chk("multu_lo", ex_to_mem_bus[31:0] === 32'hFFFF_FFFE,
        76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFE));

    @(negedge clk);
    id = f_r(6'h18, 5'd0, 32'hFFFF_FFFD, 32'd5);
    @(negedge clk);
    id = f_r(6'h12, 5'd12, 32'h0, 32'h0);
    wait_iter(n);
    chk("mult_lo", ex_to_mem_bus[31:0] === 32'hFFFF_FFF1,
        76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFF1));
    issue(f_r(6'h10, 5'd12, 32'h0, 32'h0));
    chk("mult_hi", ex_to_mem_bus[31:0] === 32'hFFFF_FFFF,
        76'(ex_to_mem_bus[31:0]), 76'(32'hFFFF_FFFF));

    issue(f_r(6'h13, 5'd0, 32'h1357_9BDF, 32'h0));
    issue(f_r(6'h12, 5'd13, 32'h0, 32'h0));
    chk("mtlo_mflo", ex_to_id_bus === {1'b1, 5'd13, 32'h1357_9BDF},
        76'(ex_to_id_bus), 76'({1'b1, 5'd13, 32'h1357_9BDF}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
